// File: rtl/qsfp_led_ctrl_if.sv
// rtl/qsfp_led_ctrl_if.sv - QSFP LED controller signal bundle
interface qsfp_led_ctrl_if;
    logic       async_link_status;
    logic       activity;
    logic       locate_req;
    logic       lamp_test;
    logic [2:0] leds;
    logic [1:0] mode;

    modport master (
        output async_link_status, activity, locate_req, lamp_test,
        input  leds, mode
    );

    modport slave (
        input  async_link_status, activity, locate_req, lamp_test,
        output leds, mode
    );
endinterface

// File: rtl/qsfp_led_ctrl.sv
// rtl/qsfp_led_ctrl.sv - QSFP link/activity/locate/lamp-test LED controller
module qsfp_led_ctrl #(
    parameter int FREQ_HZ        = 250000000,
    parameter int DEBOUNCE_MS    = 10,
    parameter int ACT_ON_MS      = 30,
    parameter int ACT_OFF_MS     = 30,
    parameter int LOCATE_HALF_MS = 250,
    parameter int LAMP_MS        = 2000
) (
    input  logic            clk,
    input  logic            resetn,
    qsfp_led_ctrl_if.slave  io
);

    // Millisecond parameters become cycle counts; 64-bit math avoids overflow at high clock rates.
    localparam longint N_DEBOUNCE    = longint'(DEBOUNCE_MS)    * longint'(FREQ_HZ) / 1000;
    localparam longint N_ACT_ON      = longint'(ACT_ON_MS)      * longint'(FREQ_HZ) / 1000;
    localparam longint N_ACT_OFF     = longint'(ACT_OFF_MS)     * longint'(FREQ_HZ) / 1000;
    localparam longint N_LOCATE_HALF = longint'(LOCATE_HALF_MS) * longint'(FREQ_HZ) / 1000;
    localparam longint N_LAMP        = longint'(LAMP_MS)        * longint'(FREQ_HZ) / 1000;
    localparam longint N_BLINK_MAX   = (N_ACT_ON > N_ACT_OFF) ? N_ACT_ON : N_ACT_OFF;

    localparam int W_DB    = $clog2(N_DEBOUNCE + 1);
    localparam int W_BLINK = $clog2(N_BLINK_MAX + 1);
    localparam int W_LOC   = $clog2(N_LOCATE_HALF + 1);
    localparam int W_LAMP  = $clog2(N_LAMP + 1);

    localparam logic [W_DB-1:0]    DB_LAST  = W_DB'(N_DEBOUNCE - 1);
    localparam logic [W_BLINK-1:0] ON_LAST  = W_BLINK'(N_ACT_ON - 1);
    localparam logic [W_BLINK-1:0] OFF_LAST = W_BLINK'(N_ACT_OFF - 1);
    localparam logic [W_LOC-1:0]   LOC_LAST = W_LOC'(N_LOCATE_HALF - 1);
    localparam logic [W_LAMP-1:0]  LAMP_LAST = W_LAMP'(N_LAMP - 1);

    // A timing parameter that rounds down to zero cycles cannot be honoured.
    if (N_DEBOUNCE < 1 || N_ACT_ON < 1 || N_ACT_OFF < 1 || N_LOCATE_HALF < 1 || N_LAMP < 1) begin : g_bad_timing
        $error("qsfp_led_ctrl: a *_MS parameter converts to zero clock cycles");
    end

    typedef enum logic [1:0] {B_IDLE, B_ON, B_OFF} blink_state_t;
    typedef enum logic [1:0] {M_NORMAL = 2'd0, M_LOCATE = 2'd1, M_LAMP = 2'd2} mode_state_t;

    logic [1:0]         sync_ff;
    logic               link_status;
    logic [W_DB-1:0]    db_cnt;
    blink_state_t       blink_state, blink_next;
    logic               pending, pending_next;
    logic [W_BLINK-1:0] blink_cnt;
    mode_state_t        mode_state, mode_next;
    logic [W_LAMP-1:0]  lamp_cnt;
    logic [W_LOC-1:0]   loc_cnt;
    logic               phase;

    // Two-flop synchronizer for the raw link status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_ff <= 2'b00;
        else         sync_ff <= {sync_ff[0], io.async_link_status};
    end

    // Debounce: accept a new link level only after it persists for the full window.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            link_status <= 1'b0;
            db_cnt      <= '0;
        end else if (sync_ff[1] == link_status) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            link_status <= sync_ff[1];
            db_cnt      <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Blinker state and pending-flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_state <= B_IDLE;
            pending     <= 1'b0;
        end else begin
            blink_state <= blink_next;
            pending     <= pending_next;
        end
    end

    // Blinker next state: activity stretched into fixed on/off windows, one pending re-blink.
    always_comb begin
        blink_next   = blink_state;
        pending_next = pending;
        case (blink_state)
            B_IDLE: if (io.activity) blink_next = B_ON;
            B_ON: begin
                if (io.activity) pending_next = 1'b1;
                if (blink_cnt == ON_LAST) blink_next = B_OFF;
            end
            B_OFF: begin
                if (io.activity) pending_next = 1'b1;
                if (blink_cnt == OFF_LAST) blink_next = (pending || io.activity) ? B_ON : B_IDLE;
            end
            default: blink_next = B_IDLE;
        endcase
        if (!link_status) blink_next = B_IDLE;
        if (blink_next == B_ON && blink_state != B_ON) pending_next = 1'b0;
        if (blink_next == B_IDLE) pending_next = 1'b0;
    end

    // Blink window counter restarts on every state change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                                 blink_cnt <= '0;
        else if (blink_next != blink_state || blink_state == B_IDLE) blink_cnt <= '0;
        else                                                         blink_cnt <= blink_cnt + 1'b1;
    end

    // Mode state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) mode_state <= M_NORMAL;
        else         mode_state <= mode_next;
    end

    // Mode selection: lamp test wins, then locate, else normal.
    always_comb begin
        mode_next = io.locate_req ? M_LOCATE : M_NORMAL;
        if (mode_state == M_LAMP && lamp_cnt != LAMP_LAST) mode_next = M_LAMP;
        if (io.lamp_test) mode_next = M_LAMP;
    end

    // Lamp-test timer; a new pulse restarts it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                          lamp_cnt <= '0;
        else if (io.lamp_test)                                lamp_cnt <= '0;
        else if (mode_state == M_LAMP && mode_next == M_LAMP) lamp_cnt <= lamp_cnt + 1'b1;
        else                                                  lamp_cnt <= '0;
    end

    // Locate half-period timer and phase; both restart whenever locate is (re)entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loc_cnt <= '0;
            phase   <= 1'b0;
        end else if (mode_state == M_LOCATE && mode_next == M_LOCATE) begin
            if (loc_cnt == LOC_LAST) begin
                loc_cnt <= '0;
                phase   <= ~phase;
            end else begin
                loc_cnt <= loc_cnt + 1'b1;
            end
        end else begin
            loc_cnt <= '0;
            phase   <= 1'b0;
        end
    end

    // Registered LED and mode outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            io.leds <= 3'b100;
            io.mode <= 2'd0;
        end else begin
            case (mode_state)
                M_LAMP:   io.leds <= 3'b111;
                M_LOCATE: io.leds <= phase ? 3'b100 : 3'b010;
                default:  io.leds <= {~link_status, link_status, blink_state == B_ON};
            endcase
            io.mode <= mode_state;
        end
    end

endmodule

// File: tb/tb_qsfp_led_ctrl.sv
// tb/tb_qsfp_led_ctrl.sv - directed self-checking bench for qsfp_led_ctrl
module tb_qsfp_led_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    qsfp_led_ctrl_if u_if();

    qsfp_led_ctrl #(
        .FREQ_HZ(1000), .DEBOUNCE_MS(10), .ACT_ON_MS(30), .ACT_OFF_MS(30),
        .LOCATE_HALF_MS(250), .LAMP_MS(2000)
    ) u_dut (
        .clk(clk),
        .resetn(resetn),
        .io(u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic run_len(input logic [2:0] mask, input logic [2:0] val, input int bound, output int n);
        n = 0;
        while (((u_if.leds & mask) == val) && n < bound) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_leds(input logic [2:0] mask, input logic [2:0] val, input int bound, output int n);
        n = 0;
        while (((u_if.leds & mask) != val) && n < bound) begin
            n++;
            @(negedge clk);
        end
        if ((u_if.leds & mask) != val) n = -1;
    endtask

    task automatic wait_mode(input logic [1:0] val, input int bound, output int n);
        n = 0;
        while (u_if.mode != val && n < bound) begin
            n++;
            @(negedge clk);
        end
        if (u_if.mode != val) n = -1;
    endtask

    task automatic pulse_activity();
        u_if.activity = 1'b1;
        @(negedge clk);
        u_if.activity = 1'b0;
    endtask

    task automatic pulse_lamp();
        u_if.lamp_test = 1'b1;
        @(negedge clk);
        u_if.lamp_test = 1'b0;
    endtask

    task automatic test_reset();
        u_if.async_link_status = 1'b0;
        u_if.activity = 1'b0;
        u_if.locate_req = 1'b0;
        u_if.lamp_test = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (u_if.leds !== 3'b100) begin tests_failed++; $display("FAIL reset_leds: got %b expected 100", u_if.leds); end
        tests_run++;
        if (u_if.mode !== 2'd0) begin tests_failed++; $display("FAIL reset_mode: got %0d expected 0", u_if.mode); end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++;
        if (u_if.leds !== 3'b100) begin tests_failed++; $display("FAIL post_reset_leds: got %b expected 100", u_if.leds); end
    endtask

    task automatic test_link_debounce();
        int n;
        int bad;
        u_if.async_link_status = 1'b1;
        wait_leds(3'b111, 3'b010, 30, n);
        tests_run++;
        if (n < 12 || n > 13) begin tests_failed++; $display("FAIL link_up_latency: got %0d cycles expected 12..13", n); end
        repeat (5) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            u_if.async_link_status = (i < 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (u_if.leds != 3'b010) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL link_glitch: got %0d changed samples expected 0", bad); end
    endtask

    task automatic test_activity();
        int n;
        int r;
        pulse_activity();
        wait_leds(3'b001, 3'b001, 5, n);
        tests_run++;
        if (n < 0) begin tests_failed++; $display("FAIL act_start: got timeout expected blink"); end
        run_len(3'b001, 3'b001, 100, r);
        tests_run++;
        if (r !== 30) begin tests_failed++; $display("FAIL act_single_on: got %0d expected 30", r); end
        run_len(3'b001, 3'b000, 40, r);
        tests_run++;
        if (r !== 40) begin tests_failed++; $display("FAIL act_single_off: got %0d expected 40", r); end

        pulse_activity();
        wait_leds(3'b001, 3'b001, 5, n);
        repeat (5) @(negedge clk);
        pulse_activity();
        run_len(3'b001, 3'b001, 100, r);
        tests_run++;
        if (6 + r !== 30) begin tests_failed++; $display("FAIL act_retrig_on1: got %0d expected 30", 6 + r); end
        run_len(3'b001, 3'b000, 100, r);
        tests_run++;
        if (r !== 30) begin tests_failed++; $display("FAIL act_retrig_gap: got %0d expected 30", r); end
        run_len(3'b001, 3'b001, 100, r);
        tests_run++;
        if (r !== 30) begin tests_failed++; $display("FAIL act_retrig_on2: got %0d expected 30", r); end
        run_len(3'b001, 3'b000, 60, r);
        tests_run++;
        if (r !== 60) begin tests_failed++; $display("FAIL act_retrig_idle: got %0d expected 60", r); end

        pulse_activity();
        wait_leds(3'b001, 3'b001, 5, n);
        for (int i = 0; i < 5; i++) begin
            pulse_activity();
            @(negedge clk);
        end
        run_len(3'b001, 3'b001, 100, r);
        tests_run++;
        if (10 + r !== 30) begin tests_failed++; $display("FAIL act_multi_on1: got %0d expected 30", 10 + r); end
        run_len(3'b001, 3'b000, 100, r);
        run_len(3'b001, 3'b001, 100, r);
        tests_run++;
        if (r !== 30) begin tests_failed++; $display("FAIL act_multi_on2: got %0d expected 30", r); end
        run_len(3'b001, 3'b000, 100, r);
        tests_run++;
        if (r !== 100) begin tests_failed++; $display("FAIL act_multi_single_extra: got %0d off cycles expected 100", r); end
    endtask

    task automatic test_link_drop();
        int n;
        int r;
        pulse_activity();
        wait_leds(3'b001, 3'b001, 5, n);
        u_if.async_link_status = 1'b0;
        repeat (16) @(negedge clk);
        tests_run++;
        if (u_if.leds !== 3'b100) begin tests_failed++; $display("FAIL link_drop_leds: got %b expected 100", u_if.leds); end
        pulse_activity();
        run_len(3'b111, 3'b100, 40, r);
        tests_run++;
        if (r !== 40) begin tests_failed++; $display("FAIL link_down_no_blink: got %0d expected 40", r); end
        u_if.async_link_status = 1'b1;
        wait_leds(3'b111, 3'b010, 30, n);
        tests_run++;
        if (n < 0) begin tests_failed++; $display("FAIL link_reup: got timeout expected 010"); end
    endtask

    task automatic test_locate();
        int n;
        int r;
        u_if.locate_req = 1'b1;
        wait_mode(2'd1, 10, n);
        tests_run++;
        if (n < 0) begin tests_failed++; $display("FAIL locate_enter: got timeout expected mode 1"); end
        run_len(3'b111, 3'b010, 300, r);
        tests_run++;
        if (r !== 250) begin tests_failed++; $display("FAIL locate_phase0: got %0d expected 250", r); end
        run_len(3'b111, 3'b100, 300, r);
        tests_run++;
        if (r !== 250) begin tests_failed++; $display("FAIL locate_phase1: got %0d expected 250", r); end
        run_len(3'b111, 3'b010, 300, r);
        tests_run++;
        if (r !== 250) begin tests_failed++; $display("FAIL locate_phase0_again: got %0d expected 250", r); end
        repeat (100) @(negedge clk);
        u_if.locate_req = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (u_if.mode !== 2'd0) begin tests_failed++; $display("FAIL locate_exit_mode: got %0d expected 0", u_if.mode); end
        tests_run++;
        if (u_if.leds !== 3'b010) begin tests_failed++; $display("FAIL locate_exit_leds: got %b expected 010", u_if.leds); end
        repeat (3) @(negedge clk);
        u_if.locate_req = 1'b1;
        wait_mode(2'd1, 10, n);
        run_len(3'b111, 3'b010, 300, r);
        tests_run++;
        if (r !== 250) begin tests_failed++; $display("FAIL locate_phase_restart: got %0d expected 250", r); end
    endtask

    task automatic test_lamp();
        int n;
        int r;
        pulse_lamp();
        wait_mode(2'd2, 10, n);
        tests_run++;
        if (n < 0) begin tests_failed++; $display("FAIL lamp_enter: got timeout expected mode 2"); end
        run_len(3'b111, 3'b111, 4000, r);
        tests_run++;
        if (r !== 2000) begin tests_failed++; $display("FAIL lamp_duration: got %0d expected 2000", r); end
        tests_run++;
        if (u_if.mode !== 2'd1) begin tests_failed++; $display("FAIL lamp_to_locate: got mode %0d expected 1", u_if.mode); end
        run_len(3'b111, 3'b010, 300, r);
        tests_run++;
        if (r !== 250) begin tests_failed++; $display("FAIL lamp_locate_phase0: got %0d expected 250", r); end

        pulse_lamp();
        wait_mode(2'd2, 10, n);
        repeat (1498) @(negedge clk);
        pulse_lamp();
        run_len(3'b111, 3'b111, 4000, r);
        tests_run++;
        if (1499 + r !== 3500) begin tests_failed++; $display("FAIL lamp_retrigger: got %0d expected 3500", 1499 + r); end
        u_if.locate_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_lamp();
        int bad;
        pulse_lamp();
        repeat (100) @(negedge clk);
        tests_run++;
        if (u_if.mode !== 2'd2) begin tests_failed++; $display("FAIL mid_lamp_mode: got %0d expected 2", u_if.mode); end
        #2;
        resetn = 1'b0;
        #1;
        tests_run++;
        if (u_if.leds !== 3'b100) begin tests_failed++; $display("FAIL async_reset_leds: got %b expected 100", u_if.leds); end
        tests_run++;
        if (u_if.mode !== 2'd0) begin tests_failed++; $display("FAIL async_reset_mode: got %0d expected 0", u_if.mode); end
        @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (u_if.mode == 2'd2 || u_if.leds == 3'b111) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL reset_no_residual_lamp: got %0d lamp samples expected 0", bad); end
        tests_run++;
        if (u_if.leds !== 3'b010) begin tests_failed++; $display("FAIL reset_link_recovers: got %b expected 010", u_if.leds); end
    endtask

    initial begin
        test_reset();
        test_link_debounce();
        test_activity();
        test_link_drop();
        test_locate();
        test_lamp();
        test_reset_mid_lamp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/qsfp_led_ctrl.md
QSFP_LED_CTRL -- requirements
Module: qsfp_led_ctrl

Interface
REQ-001 SHALL have parameter FREQ_HZ, default 250000000, the clk frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 10, the link-status debounce time.
REQ-003 SHALL have parameters ACT_ON_MS, default 30, and ACT_OFF_MS, default 30, the activity blink on-time and off-time.
REQ-004 SHALL have parameter LOCATE_HALF_MS, default 250, the locate-blink half period.
REQ-005 SHALL have parameter LAMP_MS, default 2000, the lamp-test duration.
REQ-006 SHALL convert each *_MS parameter to a cycle count N = MS*FREQ_HZ/1000 and SHALL treat any N < 1 as an elaboration error.
REQ-007 clk  input  1  the single clock; all logic is in this domain.
REQ-008 resetn  input  1  reset, asynchronous, active-low.
REQ-009 async_link_status  input  1  raw QSFP link status, asynchronous to clk.
REQ-010 activity  input  1  single-cycle traffic pulse, synchronous to clk.
REQ-011 locate_req  input  1  level; request for the identify blink.
REQ-012 lamp_test  input  1  single-cycle pulse that starts a lamp test.
REQ-013 leds  output  3  [0] green activity, [1] green link, [2] yellow link-down; all registered.
REQ-014 mode  output  2  active mode: 0 NORMAL, 1 LOCATE, 2 LAMP_TEST; registered.

Function
REQ-015 SHALL pass async_link_status through a 2-flop synchronizer before any use.
REQ-016 Debounce: internal link_status SHALL change only after the synchronized value has differed from it for N_DEBOUNCE consecutive cycles; any sample equal to link_status clears the debounce counter.
REQ-017 Blinker SHALL have exactly three states, IDLE, ON and OFF.
REQ-018 IDLE->ON SHALL occur on activity=1 when link_status=1.
REQ-019 ON SHALL last N_ACT_ON cycles, then go to OFF.
REQ-020 OFF SHALL last N_ACT_OFF cycles, then go to ON if the pending flag is set, else to IDLE.
REQ-021 Any activity pulse during ON or OFF SHALL set a single pending flag (no counting); the flag SHALL clear on entry to ON.
REQ-022 The blink LED term SHALL be 1 only in ON.
REQ-023 link_status=0 SHALL force the blinker to IDLE and clear pending on the next cycle.
REQ-024 Mode priority SHALL be LAMP_TEST > LOCATE > NORMAL; mode is re-evaluated every cycle.
REQ-025 A lamp_test pulse SHALL enter LAMP_TEST for N_LAMP cycles.
REQ-026 A lamp_test pulse arriving while already in LAMP_TEST SHALL restart the timer.
REQ-027 On LAMP_TEST expiry, mode SHALL go to LOCATE if locate_req=1, else to NORMAL.
REQ-028 LOCATE SHALL toggle the phase every N_LOCATE_HALF cycles, starting at phase 0 on entry.
REQ-029 Deasserting locate_req in LOCATE SHALL return mode to NORMAL on the next cycle and reset the phase counter.
REQ-030 The blinker and debouncer SHALL keep running in every mode.
REQ-031 NORMAL: leds SHALL be {~link_status, link_status, blink}.
REQ-032 LOCATE: leds SHALL be 3'b010 in phase 0 and 3'b100 in phase 1.
REQ-033 LAMP_TEST: leds SHALL be 3'b111.
REQ-034 leds and mode SHALL update one cycle after the internal state that drives them.
REQ-035 All counters SHALL be sized by $clog2 of their maximum count; no counter may wrap, and each SHALL saturate or reload at its terminal count.

Reset
REQ-036 resetn=0 SHALL immediately clear the synchronizer, link_status, all counters, blinker (IDLE), pending and phase.
REQ-037 During and after reset, leds SHALL be 3'b100 and mode SHALL be 0 (NORMAL).
REQ-038 Asserting reset mid-blink, mid-locate or mid-lamp-test SHALL abort the operation with no residual state after release.
REQ-039 Events SHALL be honored from the first rising clk edge after resetn deasserts.

Verification (FREQ_HZ=1000, so 1 cycle = 1 ms)
REQ-040 Link debounce: async_link_status 0->1 held -> leds goes 3'b100->3'b010 between 12 and 13 cycles later (2 sync + 10 debounce + 1 register); a 1->0 glitch of 5 cycles -> no leds change.
REQ-041 Activity stretch: link up, one activity pulse -> leds[0]=1 for exactly 30 cycles, then 0; a second pulse during ON -> a second 30-cycle blink after a 30-cycle gap; 5 pulses during ON -> still only one extra blink.
REQ-042 Link drop mid-blink: link falls while leds[0]=1 -> leds[0]=0 and leds=3'b100 once debounce completes; later activity with link down -> no blink.
REQ-043 Locate: locate_req=1 -> mode=1, leds 3'b010 for 250 cycles then 3'b100 for 250 cycles, repeating; deassert -> mode=0 and NORMAL leds next cycle.
REQ-044 Lamp priority: lamp_test pulse during LOCATE -> leds=3'b111 and mode=2 for 2000 cycles, then LOCATE resumes at phase 0; a retrigger at cycle 1500 extends the test to 3500 cycles.
REQ-045 Reset mid-operation: resetn pulsed low during LAMP_TEST -> leds=3'b100 and mode=0 immediately, with no LAMP_TEST after release.
